// File: rtl/key_pkg.sv
// Shared types and constants for the key event scheduler.
package key_pkg;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_SHORT = 2'd1,
    EV_LONG  = 2'd2
  } ev_class_t;

  localparam int unsigned DEBOUNCE_CYC_DEF = 32'd2_000_000;
  localparam int unsigned LONG_CYC_DEF     = 32'd50_000_000;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/key_event_sched_if.sv
// Valid/ready event channel carrying the key index and long/short flag.
interface key_event_sched_if
  import key_pkg::*;
#(
  parameter int NUM_KEYS = 4
);
  localparam int IDX_W = idx_w(NUM_KEYS);

  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_key;
  logic             evt_long;

  modport master (output evt_valid, output evt_key, output evt_long, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_long, output evt_ready);
endinterface

// File: rtl/key_press_classifier.sv
// Per-key synchroniser, saturating hold counter and release classifier.
module key_press_classifier
  import key_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned LONG_CYC     = LONG_CYC_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      key,
  output logic      evt,
  output ev_class_t evt_class
);
  localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC);

  logic             sync1_r;
  logic             key_s;
  logic [CNT_W-1:0] cnt_r;
  ev_class_t        cls_s;

  // Classify the press in the first cycle the synchronised key reads released.
  always_comb begin
    cls_s = EV_NONE;
    if (!key_s && (cnt_r != '0)) begin
      if (cnt_r >= LONG_LIM) begin
        cls_s = EV_LONG;
      end else if (cnt_r > DEB_LIM) begin
        cls_s = EV_SHORT;
      end else begin
        cls_s = EV_NONE;
      end
    end else begin
      cls_s = EV_NONE;
    end
  end

  // Synchroniser, saturating counter and registered event pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= 1'b0;
      key_s     <= 1'b0;
      cnt_r     <= '0;
      evt       <= 1'b0;
      evt_class <= EV_NONE;
    end else begin
      sync1_r <= key;
      key_s   <= sync1_r;
      if (key_s) begin
        cnt_r <= (cnt_r < LONG_LIM) ? cnt_r + CNT_W'(1) : cnt_r;
      end else begin
        cnt_r <= '0;
      end
      evt       <= (cls_s != EV_NONE);
      evt_class <= cls_s;
    end
  end
endmodule

// File: rtl/key_event_sched.sv
// Collects classified key presses, arbitrates them round-robin into one
// valid/ready slot and maintains the LED bank driven by accepted events.
module key_event_sched
  import key_pkg::*;
#(
  parameter int          NUM_KEYS     = 4,
  parameter int          CNT_W        = 32,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned LONG_CYC     = LONG_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  key_event_sched_if.master   evt,
  output logic [NUM_KEYS-1:0] led,
  output logic [NUM_KEYS-1:0] ovf
);
  localparam int IDX_W = idx_w(NUM_KEYS);

  logic [NUM_KEYS-1:0] kev_s;
  ev_class_t           kcls_s [NUM_KEYS];
  logic [NUM_KEYS-1:0] pend_r;
  logic [NUM_KEYS-1:0] pend_long_r;
  logic [IDX_W-1:0]    rr_ptr_r;
  logic                slot_free_s;
  logic                gnt_any_s;
  logic [IDX_W-1:0]    gnt_idx_s;
  logic [NUM_KEYS-1:0] gnt_vec_s;
  int                  pos_s;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_cls
    key_press_classifier #(
      .CNT_W       (CNT_W),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC)
    ) u_cls (
      .clk      (clk),
      .rst      (rst),
      .key      (key[g]),
      .evt      (kev_s[g]),
      .evt_class(kcls_s[g])
    );
  end

  // First pending key at or after rr_ptr, searching cyclically.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    gnt_vec_s = '0;
    pos_s     = 0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      pos_s = int'(rr_ptr_r) + k;
      if (pos_s >= NUM_KEYS) begin
        pos_s = pos_s - NUM_KEYS;
      end else begin
        pos_s = pos_s;
      end
      if (!gnt_any_s && pend_r[pos_s]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = IDX_W'(pos_s);
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
    slot_free_s = !evt.evt_valid || evt.evt_ready;
    if (slot_free_s && gnt_any_s) begin
      gnt_vec_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_vec_s = '0;
    end
  end

  // Pending events; a new event beats a same-edge grant and flags overwrites.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r      <= '0;
      pend_long_r <= '0;
      ovf         <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (kev_s[i] && (kcls_s[i] != EV_NONE)) begin
          pend_r[i]      <= 1'b1;
          pend_long_r[i] <= (kcls_s[i] == EV_LONG);
          if (pend_r[i] && !gnt_vec_s[i]) begin
            ovf[i] <= 1'b1;
          end
        end else if (gnt_vec_s[i]) begin
          pend_r[i] <= 1'b0;
        end
      end
    end
  end

  // Output slot: reload on the handshake edge for one event per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt.evt_valid <= 1'b0;
      evt.evt_key   <= '0;
      evt.evt_long  <= 1'b0;
      rr_ptr_r      <= '0;
    end else if (slot_free_s) begin
      if (gnt_any_s) begin
        evt.evt_valid <= 1'b1;
        evt.evt_key   <= gnt_idx_s;
        evt.evt_long  <= pend_long_r[gnt_idx_s];
        rr_ptr_r      <= (int'(gnt_idx_s) == NUM_KEYS - 1) ? '0 : gnt_idx_s + IDX_W'(1);
      end else begin
        evt.evt_valid <= 1'b0;
      end
    end
  end

  // LED bank follows accepted events.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else if (evt.evt_valid && evt.evt_ready) begin
      if (evt.evt_long) begin
        led <= '0;
      end else begin
        led[evt.evt_key] <= ~led[evt.evt_key];
      end
    end
  end
endmodule

// File: tb/tb_key_event_sched.sv
// Randomised self-checking bench for key_event_sched with a transaction-level model.
module tb_key_event_sched;
  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int LNG = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key;
  logic [N-1:0] led;
  logic [N-1:0] ovf;

  key_event_sched_if #(.NUM_KEYS(N)) intf ();

  key_event_sched #(
    .NUM_KEYS(N), .CNT_W(32), .DEBOUNCE_CYC(DEB), .LONG_CYC(LNG)
  ) u_dut (
    .clk(clk), .rst(rst), .key(key), .evt(intf), .led(led), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Model: pending set per key, one output slot, rr pointer, LED and ovf.
  bit         m_pend  [N];
  bit         m_plong [N];
  bit         m_slot_v;
  int         m_slot_key;
  bit         m_slot_long;
  int         m_rr;
  logic [N-1:0] m_led;
  logic [N-1:0] m_ovf;
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic void m_clear();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_plong[i] = 1'b0;
    end
    m_slot_v = 1'b0; m_slot_key = 0; m_slot_long = 1'b0;
    m_rr = 0; m_led = '0; m_ovf = '0;
  endfunction

  function automatic void m_fill();
    if (!m_slot_v) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (!m_slot_v && m_pend[idx]) begin
          m_slot_v = 1'b1; m_slot_key = idx; m_slot_long = m_plong[idx];
          m_pend[idx] = 1'b0;
          m_rr = (idx + 1) % N;
        end
      end
    end
  endfunction

  function automatic void m_add(int i, int hold);
    if (hold > DEB) begin
      if (m_pend[i]) m_ovf[i] = 1'b1;
      m_pend[i] = 1'b1;
      m_plong[i] = (hold >= LNG);
    end
  endfunction

  function automatic bit m_empty();
    bit e;
    e = !m_slot_v;
    for (int i = 0; i < N; i++) if (m_pend[i]) e = 1'b0;
    return e;
  endfunction

  // One clock: scoreboard every handshake at negedge, then return at posedge+2.
  task automatic step();
    @(negedge clk);
    if (!rst && intf.evt_valid && intf.evt_ready) begin
      n_checks++;
      if (!m_slot_v) begin
        n_fail++;
        $display("FAIL handshake: unexpected event key=%0d long=%0d, required none", intf.evt_key, intf.evt_long);
      end else begin
        if (intf.evt_key !== 2'(m_slot_key) || intf.evt_long !== m_slot_long) begin
          n_fail++;
          $display("FAIL handshake: got key=%0d long=%0d, required key=%0d long=%0d",
                   intf.evt_key, intf.evt_long, m_slot_key, m_slot_long);
        end
        if (m_slot_long) m_led = '0;
        else m_led[m_slot_key] = ~m_led[m_slot_key];
        m_slot_v = 1'b0;
        m_fill();
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [N-1:0] mask, input int hold);
    key = mask;
    repeat (hold) step();
    key = '0;
    for (int i = 0; i < N; i++) if (mask[i]) m_add(i, hold);
    m_fill();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_clear();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input bit rand_ready);
    int budget;
    budget = 0;
    while (!m_empty() && budget < 400) begin
      intf.evt_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      budget++;
    end
    intf.evt_ready = 1'b1;
    repeat (6) step();
    n_checks++;
    if (budget >= 400 || intf.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: evt_valid=%0b after %0d cycles, required 0 with model empty", intf.evt_valid, budget);
    end
  endtask

  task automatic check_led_ovf(input string tag);
    n_checks++;
    if (led !== m_led || ovf !== m_ovf) begin
      n_fail++;
      $display("FAIL %s: led=%b ovf=%b, required led=%b ovf=%b", tag, led, ovf, m_led, m_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key = '0; intf.evt_ready = 1'b1;
    m_clear();
    repeat (2) step();
    n_checks++;
    if ({intf.evt_valid, intf.evt_key, intf.evt_long, led, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset: valid=%0b key=%0d long=%0b led=%b ovf=%b, required all 0",
               intf.evt_valid, intf.evt_key, intf.evt_long, led, ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_short();
    press(4'b0001, 10);
    drain(1'b0);
    check_led_ovf("short_first");
    n_checks++;
    if (led !== 4'b0001) begin
      n_fail++; $display("FAIL short_led: led=%b, required 0001", led);
    end
    press(4'b0001, 10);
    drain(1'b0);
    check_led_ovf("short_repeat");
  endtask

  task automatic test_long();
    press(4'b0001, 8); drain(1'b0);
    press(4'b0010, 8); drain(1'b0);
    press(4'b1000, 8); drain(1'b0);
    n_checks++;
    if (led !== 4'b1011) begin
      n_fail++; $display("FAIL long_preset: led=%b, required 1011", led);
    end
    key = 4'b0100;
    repeat (30) step();
    n_checks++;
    if (u_dut.g_cls[2].u_cls.cnt_r !== 32'd20) begin
      n_fail++; $display("FAIL long_saturate: cnt=%0d, required 20", u_dut.g_cls[2].u_cls.cnt_r);
    end
    key = '0;
    m_add(2, 30); m_fill();
    drain(1'b0);
    check_led_ovf("long_clear");
  endtask

  task automatic test_glitch();
    logic [N-1:0] led_before;
    led_before = led;
    press(4'b0010, 3);
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (intf.evt_valid !== 1'b0) begin
        n_fail++; $display("FAIL glitch: evt_valid=1 at cycle %0d, required 0", c);
      end
    end
    n_checks++;
    if (led !== led_before) begin
      n_fail++; $display("FAIL glitch_led: led=%b, required %b", led, led_before);
    end
  endtask

  task automatic test_stall();
    int exp_keys [3];
    exp_keys = '{0, 1, 3};
    do_reset();
    intf.evt_ready = 1'b0;
    press(4'b1011, 10);
    repeat (6) step();
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (intf.evt_valid !== 1'b1 || intf.evt_key !== 2'd0 || intf.evt_long !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%0b key=%0d long=%0b at cycle %0d, required 1/0/0",
                 intf.evt_valid, intf.evt_key, intf.evt_long, c);
      end
      step();
    end
    intf.evt_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (intf.evt_valid !== 1'b1 || intf.evt_key !== 2'(exp_keys[j])) begin
        n_fail++;
        $display("FAIL stall_order: valid=%0b key=%0d, required 1/%0d", intf.evt_valid, intf.evt_key, exp_keys[j]);
      end
      step();
    end
    n_checks++;
    if (intf.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_end: evt_valid=1, required 0");
    end
    check_led_ovf("stall_led");
    press(4'b1001, 8);
    drain(1'b0);
    check_led_ovf("rr_wrap");
  endtask

  task automatic test_overwrite();
    intf.evt_ready = 1'b0;
    press(4'b0001, 8);
    repeat (3) step();
    press(4'b1000, 6);
    repeat (2) step();
    press(4'b1000, 7);
    repeat (6) step();
    check_led_ovf("overwrite_ovf");
    n_checks++;
    if (ovf !== 4'b1000) begin
      n_fail++; $display("FAIL overwrite_flag: ovf=%b, required 1000", ovf);
    end
    drain(1'b0);
    check_led_ovf("overwrite_drain");
  endtask

  task automatic test_reset_mid();
    intf.evt_ready = 1'b0;
    press(4'b0010, 8);
    repeat (2) step();
    press(4'b0100, 8);
    repeat (6) step();
    do_reset();
    n_checks++;
    if (intf.evt_valid !== 1'b0 || led !== '0 || ovf !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%0b led=%b ovf=%b, required 0/0000/0000", intf.evt_valid, led, ovf);
    end
    intf.evt_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      n_checks++;
      if (intf.evt_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_quiet: evt_valid=1 at cycle %0d, required 0", c);
      end
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 14; b++) begin
      logic [N-1:0] mask;
      int           hold;
      mask = N'($urandom_range(1, (1 << N) - 1));
      hold = $urandom_range(1, 30);
      press(mask, hold);
      drain(1'b1);
      check_led_ovf("random_batch");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_short();
    test_long();
    test_glitch();
    test_stall();
    test_overwrite();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
